// File: rtl/reg_to_stream_if.sv
// Bundle for reg_to_stream: the producer load port and the byte-wide TX stream.
// The slave modport is the serializer's view; the master modport is the producer/sink view.
interface reg_to_stream_if #(
    parameter int DATA_BYTES = 16
);
    logic [DATA_BYTES*8-1:0] i_data;
    logic [7:0]              i_data_len;
    logic                    i_load;
    logic                    o_load_ready;
    logic [7:0]              o_tdata;
    logic                    o_tvalid;
    logic                    i_tready;
    logic                    o_tlast;
    logic                    o_done;
    logic                    o_len_clamped;

    modport slave (
        input  i_data, i_data_len, i_load, i_tready,
        output o_load_ready, o_tdata, o_tvalid, o_tlast, o_done, o_len_clamped
    );

    modport master (
        output i_data, i_data_len, i_load, i_tready,
        input  o_load_ready, o_tdata, o_tvalid, o_tlast, o_done, o_len_clamped
    );
endinterface

// File: rtl/reg_to_stream.sv
// Captures a wide register snapshot and drains it onto a byte stream, byte 0 first, with tlast.
//   state | meaning
//   IDLE  | ready for a snapshot; stream idle
//   SEND  | shadow copy being emitted, one byte per accepted beat
module reg_to_stream #(
    parameter int DATA_BYTES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_to_stream_if.slave  bus
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [7:0] MAX_LEN = 8'(DATA_BYTES);

    state_t                  state_q;
    logic [DATA_BYTES*8-1:0] shadow_q;
    logic [7:0]              eff_len_q;
    logic [7:0]              idx_q;
    logic [7:0]              tdata_q;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic                    load_ready_q;
    logic                    done_q;
    logic                    clamped_q;

    logic                    clamp_d;
    logic [7:0]              eff_len_d;
    logic [7:0]              idx_d;
    logic [7:0]              next_byte_d;

    always_comb begin
        clamp_d     = (bus.i_data_len > MAX_LEN);
        eff_len_d   = clamp_d ? MAX_LEN : bus.i_data_len;
        idx_d       = idx_q + 8'd1;
        next_byte_d = shadow_q[{idx_d, 3'b000} +: 8];
    end

    // tdata/tlast are precomputed one beat ahead so every stream output leaves a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            eff_len_q    <= '0;
            idx_q        <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            load_ready_q <= 1'b1;
            done_q       <= 1'b0;
            clamped_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_load) begin
                        shadow_q  <= bus.i_data;
                        eff_len_q <= eff_len_d;
                        idx_q     <= '0;
                        clamped_q <= clamp_d;
                        if (eff_len_d != 8'd0) begin
                            state_q      <= SEND;
                            load_ready_q <= 1'b0;
                            tvalid_q     <= 1'b1;
                            tdata_q      <= bus.i_data[7:0];
                            tlast_q      <= (eff_len_d == 8'd1);
                        end
                    end
                end
                SEND: begin
                    if (bus.i_tready) begin
                        if (tlast_q) begin
                            state_q      <= IDLE;
                            load_ready_q <= 1'b1;
                            tvalid_q     <= 1'b0;
                            tlast_q      <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            idx_q   <= idx_d;
                            tdata_q <= next_byte_d;
                            tlast_q <= (idx_d == eff_len_q - 8'd1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_load_ready  = load_ready_q;
    assign bus.o_tdata       = tdata_q;
    assign bus.o_tvalid      = tvalid_q;
    assign bus.o_tlast       = tlast_q;
    assign bus.o_done        = done_q;
    assign bus.o_len_clamped = clamped_q;
endmodule
